// File: rtl/m3_dequant_writer.sv
// m3_dequant_writer
//   Front end of the IDCT block. Takes decoded 8x8 coefficients in zig-zag
//   order, dequantizes each one with a power-of-two step that depends on its
//   frequency position, and writes the result (S') to SRAM at its raster
//   position inside the block-tiled pre-IDCT region: all Y blocks, then U,
//   then V. Block and frame completion are reported as one-cycle pulses.
//
//   Optional build macro: DQ_SATURATE_EN
//     defined   : out-of-range dequantized values clamp to 0x8000 / 0x7FFF
//     undefined : the low 16 bits are written (wrap-around)
//
// Ports
//   CLOCK_50_I       clock
//   resetn           asynchronous active-low reset
//   dq_start         one-cycle frame start (ignored unless idle)
//   q_sel            quantization matrix select, latched on dq_start
//   coef_data        signed coefficient, zig-zag order
//   coef_valid       coef_data valid
//   coef_ready       coefficient accepted when high together with coef_valid
//   SRAM_address     write address (registered)
//   SRAM_write_data  write data (registered)
//   SRAM_we_n        write enable, active low (registered)
//   block_done       pulses with the write of a block's 64th coefficient
//   dq_end           pulses one cycle after the final write of the frame
module m3_dequant_writer #(
  parameter logic [17:0] PRE_IDCT_OFFSET = 18'd76800,
  parameter int          Y_COL_BLOCKS    = 40,
  parameter int          UV_COL_BLOCKS   = 20,
  parameter int          ROW_BLOCKS      = 30
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        dq_start,
  input  logic        q_sel,
  input  logic [15:0] coef_data,
  input  logic        coef_valid,
  output logic        coef_ready,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        block_done,
  output logic        dq_end
);

  // Row pitches are 320 (Y) and 160 (U/V) words; the row multiply below is
  // hard-wired as shift-add for exactly these values.
  localparam logic [17:0] U_BASE     = PRE_IDCT_OFFSET + 18'd76800;
  localparam logic [17:0] V_BASE     = PRE_IDCT_OFFSET + 18'd115200;
  localparam logic [5:0]  Y_BC_LAST  = 6'(Y_COL_BLOCKS - 1);
  localparam logic [5:0]  UV_BC_LAST = 6'(UV_COL_BLOCKS - 1);
  localparam logic [4:0]  BR_LAST    = 5'(ROW_BLOCKS - 1);

  // Zig-zag index -> raster position {r[2:0], c[2:0]}
  localparam logic [5:0] ZZ_LUT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    S_DQ_IDLE,
    S_DQ_RUN,
    S_DQ_FLUSH,
    S_DQ_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [5:0]  bc_q, bc_d;
  logic [4:0]  br_q, br_d;
  logic [1:0]  plane_q, plane_d;
  logic        qsel_q, qsel_d;
  logic        rdy_q, rdy_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;
  logic        bd_q, bd_d;
  logic        end_q, end_d;

  logic        xfer;
  logic [2:0]  zr, zc;
  logic [3:0]  s;
  logic [2:0]  shamt;
  logic [17:0] row18;
  logic [17:0] row_off;
  logic [17:0] base;
  logic [17:0] addr_n;
  logic [15:0] wdata_n;
  logic [5:0]  bc_last;

  assign xfer = coef_valid & rdy_q;

  // Address and data for the coefficient presented this cycle
  always_comb begin
    {zr, zc} = ZZ_LUT[k_q];
    s        = {1'b0, zr} + {1'b0, zc};
    // Both matrices reach their cap once s/2 >= 3, i.e. s >= 6.
    if (s >= 4'd6) shamt = qsel_q ? 3'd4 : 3'd6;
    else           shamt = 3'(s >> 1) + (qsel_q ? 3'd1 : 3'd3);

    row18 = {10'd0, br_q, zr};           // br*8 + r
    if (plane_q == 2'd0) row_off = (row18 << 8) + (row18 << 6);
    else                 row_off = (row18 << 7) + (row18 << 5);
    case (plane_q)
      2'd0:    base = PRE_IDCT_OFFSET;
      2'd1:    base = U_BASE;
      default: base = V_BASE;
    endcase
    addr_n  = base + row_off + {9'd0, bc_q, zc};  // + bc*8 + c
    bc_last = (plane_q == 2'd0) ? Y_BC_LAST : UV_BC_LAST;
  end

`ifdef DQ_SATURATE_EN
  logic [23:0] dq_wide;
  always_comb begin
    dq_wide = {{8{coef_data[15]}}, coef_data} << shamt;
    // In range exactly when bits 23..15 all equal the sign.
    if (!dq_wide[23] && (|dq_wide[22:15]))      wdata_n = 16'h7FFF;
    else if (dq_wide[23] && !(&dq_wide[22:15])) wdata_n = 16'h8000;
    else                                        wdata_n = dq_wide[15:0];
  end
`else
  // Wrap-around keeps only the low 16 bits, which a 16-bit shift yields.
  always_comb wdata_n = coef_data << shamt;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bc_d    = bc_q;
    br_d    = br_q;
    plane_d = plane_q;
    qsel_d  = qsel_q;
    rdy_d   = rdy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    bd_d    = 1'b0;
    end_d   = 1'b0;
    case (state_q)
      S_DQ_IDLE: begin
        if (dq_start) begin
          qsel_d  = q_sel;
          k_d     = 6'd0;
          bc_d    = 6'd0;
          br_d    = 5'd0;
          plane_d = 2'd0;
          rdy_d   = 1'b1;
          state_d = S_DQ_RUN;
        end
      end
      S_DQ_RUN: begin
        if (xfer) begin
          addr_d  = addr_n;
          wdata_d = wdata_n;
          we_n_d  = 1'b0;
          k_d     = k_q + 6'd1;
          if (k_q == 6'd63) begin
            bd_d = 1'b1;
            if (bc_q == bc_last) begin
              bc_d = 6'd0;
              if (br_q == BR_LAST) begin
                br_d = 5'd0;
                if (plane_q == 2'd2) begin
                  rdy_d   = 1'b0;
                  state_d = S_DQ_FLUSH;
                end else begin
                  plane_d = plane_q + 2'd1;
                end
              end else begin
                br_d = br_q + 5'd1;
              end
            end else begin
              bc_d = bc_q + 6'd1;
            end
          end
        end
      end
      // Final write is on the bus this cycle; dq_end follows next cycle.
      S_DQ_FLUSH: begin
        end_d   = 1'b1;
        state_d = S_DQ_DONE;
      end
      S_DQ_DONE: state_d = S_DQ_IDLE;
      default:   state_d = S_DQ_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_DQ_IDLE;
      k_q     <= 6'd0;
      bc_q    <= 6'd0;
      br_q    <= 5'd0;
      plane_q <= 2'd0;
      qsel_q  <= 1'b0;
      rdy_q   <= 1'b0;
      addr_q  <= 18'd0;
      wdata_q <= 16'd0;
      we_n_q  <= 1'b1;
      bd_q    <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bc_q    <= bc_d;
      br_q    <= br_d;
      plane_q <= plane_d;
      qsel_q  <= qsel_d;
      rdy_q   <= rdy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      bd_q    <= bd_d;
      end_q   <= end_d;
    end
  end

  assign coef_ready      = rdy_q;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign block_done      = bd_q;
  assign dq_end          = end_q;

endmodule

// File: tb/tb_m3_dequant_writer.sv
// Testbench for m3_dequant_writer. Built with a reduced ROW_BLOCKS so that a
// complete frame fits in a short run; plane bases and pitches are unchanged.
module tb_m3_dequant_writer;
  localparam int RB    = 2;
  localparam int YB    = RB * 40;
  localparam int UB    = RB * 20;
  localparam int VB    = RB * 20;
  localparam int TOTAL = (YB + UB + VB) * 64;
`ifdef DQ_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        CLOCK_50_I = 1'b0;
  logic        resetn = 1'b0;
  logic        dq_start = 1'b0;
  logic        q_sel = 1'b0;
  logic [15:0] coef_data = 16'd0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        block_done;
  logic        dq_end;

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  m3_dequant_writer #(.ROW_BLOCKS(RB)) dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .resetn          (resetn),
    .dq_start        (dq_start),
    .q_sel           (q_sel),
    .coef_data       (coef_data),
    .coef_valid      (coef_valid),
    .coef_ready      (coef_ready),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .block_done      (block_done),
    .dq_end          (dq_end)
  );

  int nvec = 0;
  int nerr = 0;
  int zr [64];
  int zc [64];
  int n, wr_cnt, bd_cnt, end_cnt;
  bit qs_ref;
  bit end_pend;

  typedef struct {
    bit qs;
    int k;
    int val;
    int exp_addr;
    int exp_data;
  } vec_t;
  vec_t tbl [12];

  task automatic cmp(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic int ref_addr(input int idx);
    int b, k, base, pitch, cols, bl;
    b = idx / 64;
    k = idx % 64;
    if (b < YB)           begin base = 76800;  pitch = 320; cols = 40; bl = b;           end
    else if (b < YB + UB) begin base = 153600; pitch = 160; cols = 20; bl = b - YB;      end
    else                  begin base = 192000; pitch = 160; cols = 20; bl = b - YB - UB; end
    return base + ((bl / cols) * 8 + zr[k]) * pitch + (bl % cols) * 8 + zc[k];
  endfunction

  function automatic int ref_data(input bit qs, input int k, input int v);
    int s, sh, cap;
    longint x;
    s   = zr[k] + zc[k];
    sh  = qs ? 1 + s / 2 : 3 + s / 2;
    cap = qs ? 4 : 6;
    if (sh > cap) sh = cap;
    x = longint'(v) * longint'(2 ** sh);
    if (SAT) begin
      if (x > 32767)       x = 32767;
      else if (x < -32768) x = -32768;
    end
    return int'(x & 64'hFFFF);
  endfunction

  // Checks the outputs produced by the edge just passed.
  task automatic check(input bit xf, input logic [15:0] d);
    cmp("dq_end", int'(dq_end), int'(end_pend));
    end_cnt += int'(dq_end);
    end_pend = xf && (n == TOTAL - 1);
    if (xf) begin
      cmp("we_n", int'(SRAM_we_n), 0);
      cmp("addr", int'(SRAM_address), ref_addr(n));
      cmp("data", int'(SRAM_write_data), ref_data(qs_ref, n % 64, int'($signed(d))));
      cmp("block_done", int'(block_done), int'(n % 64 == 63));
      wr_cnt++;
      bd_cnt += int'(block_done);
      if (n == 63) begin
        cmp("blk0_writes", wr_cnt, 64);
        cmp("blk0_done_pulses", bd_cnt, 1);
      end
      if (n == 64)          cmp("blk1_k0_addr", int'(SRAM_address), 76808);
      if (n == YB * 64)     cmp("u_first_addr", int'(SRAM_address), 153600);
      if (n == YB * 64 + 2) cmp("u_row1_addr", int'(SRAM_address), 153760);
      if (n == TOTAL - 1)   cmp("final_addr", int'(SRAM_address), 192000 + ((RB - 1) * 8 + 7) * 160 + 159);
      n++;
    end else begin
      cmp("we_n_idle", int'(SRAM_we_n), 1);
      cmp("block_done_idle", int'(block_done), 0);
    end
  endtask

  // Called at posedge+1: drive inputs, let one edge pass, check.
  task automatic step(input bit v, input logic [15:0] d, input bit st);
    bit xf;
    coef_valid = v;
    coef_data  = d;
    dq_start   = st;
    xf = v && coef_ready;
    @(posedge CLOCK_50_I);
    #1;
    check(xf, d);
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    dq_start   = 1'b0;
    coef_valid = 1'b0;
    coef_data  = 16'd0;
    end_pend   = 1'b0;
    @(posedge CLOCK_50_I);
    #1;
    cmp("rst_addr", int'(SRAM_address), 0);
    cmp("rst_data", int'(SRAM_write_data), 0);
    cmp("rst_we_n", int'(SRAM_we_n), 1);
    cmp("rst_ready", int'(coef_ready), 0);
    cmp("rst_block_done", int'(block_done), 0);
    cmp("rst_dq_end", int'(dq_end), 0);
    resetn = 1'b1;
  endtask

  task automatic start(input bit qs);
    n = 0; wr_cnt = 0; bd_cnt = 0; end_cnt = 0;
    q_sel  = qs;
    qs_ref = qs;
    step(1'b0, 16'd0, 1'b1);
    q_sel = ~qs;  // must have been latched already
    cmp("ready_after_start", int'(coef_ready), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kk, cyc;
    bit v;
    kk = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zr[kk] = r; zc[kk] = s - r; kk++; end
      else            for (int r = lo; r <= hi; r++) begin zr[kk] = r; zc[kk] = s - r; kk++; end
    end

    tbl[0]  = '{1'b0, 0,  5,      76800, 'h0028};
    tbl[1]  = '{1'b0, 1,  -3,     76801, 'hFFE8};
    tbl[2]  = '{1'b0, 2,  1,      77120, 'h0008};
    tbl[3]  = '{1'b0, 63, 'h1000, 79047, SAT ? 'h7FFF : 'h0000};
    tbl[4]  = '{1'b1, 0,  5,      76800, 'h000A};
    tbl[5]  = '{1'b1, 63, 1,      79047, 'h0010};
    tbl[6]  = '{1'b0, 63, -1,     79047, 'hFFC0};
    tbl[7]  = '{1'b0, 5,  7,      76802, 'h0070};
    tbl[8]  = '{1'b0, 3,  2,      77440, 'h0020};
    tbl[9]  = '{1'b0, 63, -32768, 79047, SAT ? 'h8000 : 'h0000};
    tbl[10] = '{1'b1, 63, 'h1000, 79047, SAT ? 'h7FFF : 'h0000};
    tbl[11] = '{1'b1, 4,  3,      77121, 'h000C};

    for (int i = 0; i < 12; i++) begin
      do_reset();
      start(tbl[i].qs);
      for (int j = 0; j < tbl[i].k; j++) step(1'b1, 16'd0, 1'b0);
      step(1'b1, 16'(tbl[i].val), 1'b0);
      cmp($sformatf("tbl%0d_we_n", i), int'(SRAM_we_n), 0);
      cmp($sformatf("tbl%0d_addr", i), int'(SRAM_address), tbl[i].exp_addr);
      cmp($sformatf("tbl%0d_data", i), int'(SRAM_write_data), tbl[i].exp_data);
    end

    // Full frames, Q0 then Q1; the second restarts from idle without reset.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      start(f[0]);
      cyc = 0;
      while (n < TOTAL && cyc < 40000) begin
        if (n < 64) v = (cyc % 2 == 0);
        else        v = ($urandom_range(0, 3) != 0);
        step(v, 16'($urandom), cyc == 500);
        cyc++;
      end
      cmp("frame_complete", n, TOTAL);
      for (int j = 0; j < 3; j++) step(1'b1, 16'($urandom), 1'b0);
      cmp("dq_end_pulses", end_cnt, 1);
      cmp("total_writes", wr_cnt, TOTAL);
      cmp("total_block_done", bd_cnt, TOTAL / 64);
      cmp("ready_after_done", int'(coef_ready), 0);
    end

    // Reset in the middle of a frame
    start(1'b0);
    for (int j = 0; j < 100; j++) step(1'b1, 16'($urandom), 1'b0);
    cmp("pre_reset_we_n", int'(SRAM_we_n), 0);
    resetn = 1'b0;
    #1;
    cmp("midrst_we_n", int'(SRAM_we_n), 1);
    cmp("midrst_ready", int'(coef_ready), 0);
    cmp("midrst_addr", int'(SRAM_address), 0);
    cmp("midrst_block_done", int'(block_done), 0);
    coef_valid = 1'b0;
    end_pend   = 1'b0;
    @(posedge CLOCK_50_I);
    #1;
    resetn = 1'b1;
    start(1'b0);
    step(1'b1, 16'd5, 1'b0);
    cmp("restart_addr", int'(SRAM_address), 76800);
    cmp("restart_data", int'(SRAM_write_data), 'h0028);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
